fractal_engine: RTL and testbench

FRACTAL_ENGINE -- requirements
Module: fractal_engine

---
 rtl/fractal_engine.sv | 166 ++++++++++++++++
 tb/tb_fractal_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_engine.sv
// Mandelbrot/Julia escape-time engine: one point per request, MUL/UPD iteration loop.
// Optional final |z|^2 output enabled by defining FRACTAL_ENGINE_MAG_OUT_EN.
module fractal_engine #(
  parameter int FP_WIDTH = 25,
  parameter int FP_INT   = 4,
  parameter int ITER_MAX = 255,
  parameter int ITERW    = $clog2(ITER_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic signed [FP_WIDTH-1:0] re,
  input  logic signed [FP_WIDTH-1:0] im,
  input  logic signed [FP_WIDTH-1:0] jre,
  input  logic signed [FP_WIDTH-1:0] jim,
  input  logic [ITERW-1:0]           max_iter,
  input  logic                       abort,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ITERW-1:0]           iter,
  output logic                       escaped,
  output logic                       busy
`ifdef FRACTAL_ENGINE_MAG_OUT_EN
  ,
  output logic [FP_WIDTH:0]          mag2_out
`endif
);

  localparam int W    = FP_WIDTH;
  localparam int FRAC = FP_WIDTH - FP_INT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] UPD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [W:0] MAG_LIMIT = (W + 1)'(4) << FRAC;

  if (FP_INT < 4) begin : g_bad_fp_int
    $error("fractal_engine: FP_INT must be at least 4");
  end

  logic [1:0]       state_reg;
  logic             rdy_en_reg;
  logic [W-1:0]     x_reg, y_reg, cr_reg, ci_reg;
  logic [W-1:0]     x2_reg, y2_reg, xy_reg;
  logic [ITERW-1:0] limit_reg;
  logic [ITERW-1:0] limit_in;

  logic [2*W-1:0]   x_ext, y_ext, xx_full, yy_full, xy_full;
  logic [W-1:0]     x2_next, y2_next, xy_next;
  logic [W:0]       mag2;
  logic [W-1:0]     x_upd, y_upd;
  logic             unused_bits;

  if ((2 ** ITERW) - 1 > ITER_MAX) begin : g_clamp
    assign limit_in = (max_iter > ITERW'(ITER_MAX)) ? ITERW'(ITER_MAX) : max_iter;
  end else begin : g_noclamp
    assign limit_in = max_iter;
  end

  assign x_ext   = {{W{x_reg[W-1]}}, x_reg};
  assign y_ext   = {{W{y_reg[W-1]}}, y_reg};
  assign xx_full = x_ext * x_ext;
  assign yy_full = y_ext * y_ext;
  assign xy_full = x_ext * y_ext;

  // Squares are non-negative, so they are kept unsigned and saturate instead of
  // wrapping; a far-out orbit must never alias back inside the radius-2 circle.
  assign x2_next = (|xx_full[2*W-1:W+FRAC]) ? '1 : xx_full[W+FRAC-1:FRAC];
  assign y2_next = (|yy_full[2*W-1:W+FRAC]) ? '1 : yy_full[W+FRAC-1:FRAC];
  assign xy_next = xy_full[W+FRAC-1:FRAC];

  assign unused_bits = ^{xx_full[FRAC-1:0], yy_full[FRAC-1:0],
                         xy_full[2*W-1:W+FRAC], xy_full[FRAC-1:0]};

  assign mag2  = {1'b0, x2_reg} + {1'b0, y2_reg};
  assign x_upd = x2_reg - y2_reg + cr_reg;
  assign y_upd = {xy_reg[W-2:0], 1'b0} + ci_reg;

  // in_ready stays low until the first clock after reset release.
  assign in_ready  = (state_reg == IDLE) && rdy_en_reg;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rdy_en_reg <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      cr_reg     <= '0;
      ci_reg     <= '0;
      x2_reg     <= '0;
      y2_reg     <= '0;
      xy_reg     <= '0;
      limit_reg  <= '0;
      iter       <= '0;
      escaped    <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
      if (abort && (state_reg != IDLE)) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (in_valid && in_ready) begin
              if (mode) begin
                x_reg  <= re;
                y_reg  <= im;
                cr_reg <= jre;
                ci_reg <= jim;
              end else begin
                x_reg  <= '0;
                y_reg  <= '0;
                cr_reg <= re;
                ci_reg <= im;
              end
              limit_reg <= limit_in;
              iter      <= '0;
              escaped   <= 1'b0;
              state_reg <= MUL;
            end
          end
          MUL: begin
            x2_reg    <= x2_next;
            y2_reg    <= y2_next;
            xy_reg    <= xy_next;
            state_reg <= UPD;
          end
          UPD: begin
            if (mag2 > MAG_LIMIT) begin
              escaped   <= 1'b1;
              state_reg <= DONE;
            end else if (iter == limit_reg) begin
              escaped   <= 1'b0;
              state_reg <= DONE;
            end else begin
              x_reg     <= x_upd;
              y_reg     <= y_upd;
              iter      <= iter + 1'b1;
              state_reg <= MUL;
            end
          end
          default: begin
            if (out_ready) state_reg <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef FRACTAL_ENGINE_MAG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag2_out <= '0;
    end else if ((state_reg == UPD) && !abort &&
                 ((mag2 > MAG_LIMIT) || (iter == limit_reg))) begin
      mag2_out <= mag2;
    end
  end
`endif

endmodule

// File: tb/tb_fractal_engine.sv
// Directed bench for fractal_engine: expected results queued at accept, checked on out_valid.
// Covers latency, hold, abort and asynchronous reset; checks mag2_out when FRACTAL_ENGINE_MAG_OUT_EN is set.
module tb_fractal_engine;

  localparam int W    = 25;
  localparam int ONE  = 1 << 21;
  localparam int SAT  = (1 << 25) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [W-1:0] re, im, jre, jim;
  logic [7:0]          max_iter;
  logic                abort;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          iter;
  logic                escaped;
  logic                busy;
`ifdef FRACTAL_ENGINE_MAG_OUT_EN
  logic [W:0]          mag2_out;
`endif

  typedef struct {
    int   it;
    logic esc;
    int   lat;
    int   mag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fractal_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .re        (re),
    .im        (im),
    .jre       (jre),
    .jim       (jim),
    .max_iter  (max_iter),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .iter      (iter),
    .escaped   (escaped),
    .busy      (busy)
`ifdef FRACTAL_ENGINE_MAG_OUT_EN
    ,
    .mag2_out  (mag2_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one request; inputs are scrambled right after the accept edge.
  task automatic send(input logic m, input int r, input int i, input int jr, input int ji,
                      input int mi, input bit push, input logic ab,
                      input int e_it, input logic e_esc, input int e_mag);
    @(negedge clk);
    mode     = m;
    re       = W'(r);
    im       = W'(i);
    jre      = W'(jr);
    jim      = W'(ji);
    max_iter = 8'(mi);
    abort    = ab;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    if (push) exp_q.push_back('{e_it, e_esc, 2 * (e_it + 1), e_mag});
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    mode     = ~m;
    re       = W'(5 * ONE);
    im       = W'(-3 * ONE);
    jre      = W'(3 * ONE);
    jim      = W'(ONE);
    max_iter = 8'hff;
  endtask

  // Wait for a result, compare against the queue head, hold, then hand off or abort.
  task automatic collect(input string tag, input int hold_n, input bit use_abort);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 0;
    while (!got && lat < 600) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) got = 1;
    end
    check({tag, "_out_valid_seen"}, got, 1);
    if (!got) return;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_unexpected_result: observed result expected none", tag);
      return;
    end
    e = exp_q.pop_front();
    $display("%s: iter=%0d escaped=%0d latency=%0d", tag, iter, escaped, lat);
    check({tag, "_latency"}, lat, e.lat);
    check({tag, "_iter"}, iter, e.it);
    check({tag, "_escaped"}, escaped, e.esc);
    check({tag, "_in_ready_done"}, in_ready, 0);
    check({tag, "_busy_done"}, busy, 1);
`ifdef FRACTAL_ENGINE_MAG_OUT_EN
    if (e.mag >= 0) check({tag, "_mag2"}, mag2_out, e.mag);
`endif
    for (int k = 0; k < hold_n; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_iter"}, iter, e.it);
      check({tag, "_hold_escaped"}, escaped, e.esc);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    if (use_abort) abort = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    abort     = 1'b0;
    check({tag, "_after_valid"}, out_valid, 0);
    check({tag, "_after_busy"}, busy, 0);
    check({tag, "_after_in_ready"}, in_ready, 1);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check({tag, "_no_result"}, seen, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    re        = '0;
    im        = '0;
    jre       = '0;
    jim       = '0;
    max_iter  = '0;
    abort     = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_iter", iter, 0);
    check("rst_escaped", escaped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rdy_before_first_clk", in_ready, 0);
    @(posedge clk);
    #1;
    check("rdy_after_first_clk", in_ready, 1);

    send(0, 2 * ONE, 0, 0, 0, 255, 1, 0, 2, 1, SAT);
    collect("mand_c2", 0, 0);
    send(0, 0, 0, 0, 0, 10, 1, 0, 10, 0, 0);
    collect("mand_c0_m10", 0, 0);
    send(1, 3 * ONE, 0, 0, 0, 5, 1, 0, 0, 1, 9 * ONE);
    collect("julia_z3", 0, 0);
    send(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    collect("julia_m0", 0, 0);
    send(0, ONE, 0, 0, 0, 255, 1, 0, 3, 1, SAT);
    collect("mand_c1", 0, 0);
    send(0, 0, ONE, 0, 0, 20, 1, 0, 20, 0, 2 * ONE);
    collect("mand_ci", 0, 0);
    send(0, 0, 2 * ONE, 0, 0, 255, 1, 0, 2, 1, SAT + 4 * ONE);
    collect("mand_c2i", 0, 0);
    send(0, -2 * ONE, 0, 0, 0, 6, 1, 0, 6, 0, 4 * ONE);
    collect("mand_cm2_edge", 0, 0);
    send(0, ONE / 4, 0, 0, 0, 30, 1, 0, 30, 0, -1);
    collect("mand_quarter", 0, 0);
    send(0, 0, 0, 0, 0, 255, 1, 0, 255, 0, 0);
    collect("mand_c0_m255", 0, 0);

    send(0, -ONE, 0, 0, 0, 7, 1, 0, 7, 0, ONE);
    collect("hold_cm1", 20, 0);

    send(0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    watch_quiet("abort", 30);
    send(0, 2 * ONE, 0, 0, 0, 255, 1, 0, 2, 1, SAT);
    collect("after_abort", 0, 0);

    send(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    collect("abort_in_done", 0, 1);
    send(0, ONE, 0, 0, 0, 255, 1, 1, 3, 1, SAT);
    collect("abort_idle_ignored", 0, 0);

    send(0, 0, 0, 0, 0, 100, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_iter", iter, 0);
    check("midrst_escaped", escaped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rdy_before_clk", in_ready, 0);
    @(posedge clk);
    #1;
    check("midrst_rdy_after_clk", in_ready, 1);
    watch_quiet("midrst", 20);
    send(0, 0, ONE, 0, 0, 4, 1, 0, 4, 0, 2 * ONE);
    collect("after_midrst", 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
